// File: rtl/xor_rot_encrypter_pipe.sv
// xor_rot_encrypter_pipe: loads a key word, then encrypts each data word as
// data ^ rotl(key, amt) through one register stage into an output FIFO.
// Optional feature macro: ENCRYPTER_KEY_WHITEN_EN (rotation amount is XORed
// with the low key bits before use).
module xor_rot_encrypter_pipe #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ROT_WIDTH  = $clog2(WIDTH),
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              data_in_p,
   input  logic [ROT_WIDTH-1:0]          key_rotation_p,
   input  logic                          prog_p,
   input  logic                          data_ready_in_p,
   output logic                          ready_p,
   output logic [WIDTH-1:0]              data_out_c,
   output logic                          data_ready_out_c,
   input  logic                          capture_c,
   output logic                          key_loaded,
   output logic                          err_nokey,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(WIDTH);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW:0] DEPTH_L = (LW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, KEYED} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     key_q, key_d;
   logic                 err_q, err_d;
   logic                 s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0]     s1_data_q, s1_data_d;
   logic [WIDTH-1:0]     s1_rk_q, s1_rk_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];

   logic [ROT_WIDTH-1:0] amt_raw;
   logic [AW-1:0]        amt;
   logic [WIDTH-1:0]     rk;
   logic [LW:0]          used;
   logic                 accept;
   logic                 push;
   logic                 pop;

`ifdef ENCRYPTER_KEY_WHITEN_EN
   assign amt_raw = key_rotation_p ^ key_q[ROT_WIDTH-1:0];
`else
   assign amt_raw = key_rotation_p;
`endif

   // Reduce the rotation amount modulo WIDTH (power of two: keep low bits)
   generate
      if (ROT_WIDTH >= AW) begin : g_amt_trunc
         assign amt = amt_raw[AW-1:0];
      end else begin : g_amt_ext
         assign amt = {{(AW-ROT_WIDTH){1'b0}}, amt_raw};
      end
   endgenerate

   // Rotate-left by index arithmetic mod WIDTH; never shifts by WIDTH
   always_comb begin
      rk = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         rk[i] = key_q[AW'(i) - amt];
      end
   end

   assign used     = {1'b0, level_q} + {{LW{1'b0}}, s1_vld_q};
   assign ready_p  = reset && (used < DEPTH_L);
   assign accept   = data_ready_in_p && ready_p;
   assign push     = s1_vld_q;
   assign pop      = capture_c && (level_q != '0);

   assign data_ready_out_c = (level_q != '0);
   assign data_out_c       = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign key_loaded       = (state_q == KEYED);
   assign err_nokey        = err_q;
   assign fifo_level       = level_q;

   // Key FSM next state plus stage-1 capture of data and rotated key
   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      err_d     = err_q;
      s1_vld_d  = 1'b0;
      s1_data_d = s1_data_q;
      s1_rk_d   = s1_rk_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (prog_p) begin
                  key_d   = data_in_p;
                  state_d = KEYED;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         KEYED: begin
            if (accept) begin
               if (prog_p) begin
                  key_d = data_in_p;
               end else begin
                  s1_vld_d  = 1'b1;
                  s1_data_d = data_in_p;
                  s1_rk_d   = rk;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointer and occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // State, key, pipeline and FIFO control registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         key_q     <= '0;
         err_q     <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_rk_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         err_q     <= err_d;
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_rk_q   <= s1_rk_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
      end
   end

   // Stage 2: ciphertext written into FIFO storage
   always_ff @(posedge clk) begin
      if (reset && push) mem_q[wr_ptr_q] <= s1_data_q ^ s1_rk_q;
   end

endmodule

// File: tb/tb_xor_rot_encrypter_pipe.sv
// Directed bench for xor_rot_encrypter_pipe (WIDTH=32, FIFO_DEPTH=4).
// Expected ciphertexts for key 0x000000FF change when ENCRYPTER_KEY_WHITEN_EN
// is defined; other keys have zero low bits so whitening leaves them alone.
module tb_xor_rot_encrypter_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] data_in_p = '0;
   logic [4:0]  key_rotation_p = '0;
   logic        prog_p = 1'b0;
   logic        data_ready_in_p = 1'b0;
   logic        ready_p;
   logic [31:0] data_out_c;
   logic        data_ready_out_c;
   logic        capture_c = 1'b0;
   logic        key_loaded;
   logic        err_nokey;
   logic [2:0]  fifo_level;

   int unsigned n_checks = 0;
   int unsigned n_err = 0;

   localparam logic [31:0] K1 = 32'hA5A5A5A0;
   localparam logic [31:0] K2 = 32'h3C3C3C00;
`ifdef ENCRYPTER_KEY_WHITEN_EN
   localparam logic [31:0] EXP_BASIC = 32'hEA34567F;
   localparam logic [31:0] EXP_R28   = 32'h000007F8;
   localparam logic [31:0] EXP_R0    = 32'h8000007F;
`else
   localparam logic [31:0] EXP_BASIC = 32'h12345988;
   localparam logic [31:0] EXP_R28   = 32'hF000000F;
   localparam logic [31:0] EXP_R0    = 32'h000000FF;
`endif

   xor_rot_encrypter_pipe #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .data_in_p        (data_in_p),
      .key_rotation_p   (key_rotation_p),
      .prog_p           (prog_p),
      .data_ready_in_p  (data_ready_in_p),
      .ready_p          (ready_p),
      .data_out_c       (data_out_c),
      .data_ready_out_c (data_ready_out_c),
      .capture_c        (capture_c),
      .key_loaded       (key_loaded),
      .err_nokey        (err_nokey),
      .fifo_level       (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word for one edge; it must be accepted on that edge
   task automatic send(input string tag, input logic prog, input logic [31:0] d,
                       input logic [4:0] rot);
      prog_p          = prog;
      data_in_p       = d;
      key_rotation_p  = rot;
      data_ready_in_p = 1'b1;
      check({tag, "_rdy"}, 64'(ready_p), 64'd1);
      tick();
      data_ready_in_p = 1'b0;
      prog_p          = 1'b0;
   endtask

   // Wait (bounded) for a FIFO head, compare it, then pop it
   task automatic expect_out(input string tag, input logic [31:0] exp);
      for (int i = 0; i < 8 && !data_ready_out_c; i++) tick();
      check({tag, "_vld"}, 64'(data_ready_out_c), 64'd1);
      check(tag, 64'(data_out_c), 64'(exp));
      capture_c = 1'b1;
      tick();
      capture_c = 1'b0;
   endtask

   logic [31:0] words [6];
   int unsigned idx;
   logic        acc;

   initial begin
      // Reset state
      tick();
      check("rst_ready", 64'(ready_p), 64'd0);
      check("rst_dout", 64'(data_out_c), 64'd0);
      check("rst_drdy", 64'(data_ready_out_c), 64'd0);
      check("rst_keyld", 64'(key_loaded), 64'd0);
      check("rst_err", 64'(err_nokey), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      reset = 1'b1;
      #1;
      check("rel_ready", 64'(ready_p), 64'd1);

      // Data before any key is dropped and flags the error
      send("nokey", 1'b0, 32'h0000_0011, 5'd0);
      check("nokey_err", 64'(err_nokey), 64'd1);
      check("nokey_keyld", 64'(key_loaded), 64'd0);
      tick();
      check("nokey_level", 64'(fifo_level), 64'd0);
      check("nokey_drdy", 64'(data_ready_out_c), 64'd0);

      // Basic encrypt and latency
      send("key_ff", 1'b1, 32'h0000_00FF, 5'd0);
      check("key_ff_loaded", 64'(key_loaded), 64'd1);
      send("basic", 1'b0, 32'h1234_5678, 5'd4);
      check("basic_drdy_early", 64'(data_ready_out_c), 64'd0);
      tick();
      check("basic_drdy", 64'(data_ready_out_c), 64'd1);
      check("basic_level", 64'(fifo_level), 64'd1);
      expect_out("basic_out", EXP_BASIC);
      check("basic_empty_dout", 64'(data_out_c), 64'd0);
      check("basic_empty_level", 64'(fifo_level), 64'd0);

      // Wrap-around rotation and rotation by zero, back to back
      send("r28", 1'b0, 32'h0000_0000, 5'd28);
      send("r0", 1'b0, 32'h0000_0000, 5'd0);
      tick();
      check("wrap_level", 64'(fifo_level), 64'd2);
      expect_out("r28_out", EXP_R28);
      expect_out("r0_out", EXP_R0);

      // Key change mid-stream
      send("k1", 1'b1, K1, 5'd0);
      send("d1", 1'b0, 32'h0F0F_0F0F, 5'd8);
      send("k2", 1'b1, K2, 5'd0);
      send("d2", 1'b0, 32'hFFFF_0000, 5'd4);
      expect_out("d1_out", 32'hAAAA_AFAA);
      expect_out("d2_out", 32'h3C3C_C003);

      // Backpressure: collector stalled, six words offered
      for (int i = 0; i < 6; i++) words[i] = 32'h1000_0001 + 32'(i);
      idx = 0;
      data_in_p       = words[0];
      key_rotation_p  = 5'd0;
      data_ready_in_p = 1'b1;
      for (int c = 0; c < 8; c++) begin
         acc = ready_p;
         tick();
         if (acc) begin
            idx++;
            if (idx < 6) data_in_p = words[idx];
         end
      end
      check("bp_accepted", 64'(idx), 64'd4);
      check("bp_ready", 64'(ready_p), 64'd0);
      check("bp_level", 64'(fifo_level), 64'd4);
      check("bp_head", 64'(data_out_c), 64'(words[0] ^ K2));
      capture_c = 1'b1;
      acc = ready_p;
      tick();
      capture_c = 1'b0;
      if (acc) idx++;
      check("bp_pop_ready", 64'(ready_p), 64'd1);
      check("bp_pop_level", 64'(fifo_level), 64'd3);
      check("bp_no_accept_while_full", 64'(idx), 64'd4);
      tick();
      idx++;
      data_ready_in_p = 1'b0;
      check("bp_full_again", 64'(ready_p), 64'd0);
      for (int i = 1; i < 5; i++) expect_out($sformatf("bp_out%0d", i), words[i] ^ K2);
      check("bp_drained", 64'(fifo_level), 64'd0);

      // Reset mid-operation: three queued plus one in flight
      for (int i = 0; i < 4; i++) send($sformatf("pre_rst%0d", i), 1'b0, 32'h5555_0000 + 32'(i), 5'd0);
      check("pre_rst_level", 64'(fifo_level), 64'd3);
      check("pre_rst_err", 64'(err_nokey), 64'd1);
      reset = 1'b0;
      tick();
      check("mid_rst_ready", 64'(ready_p), 64'd0);
      check("mid_rst_drdy", 64'(data_ready_out_c), 64'd0);
      check("mid_rst_dout", 64'(data_out_c), 64'd0);
      check("mid_rst_level", 64'(fifo_level), 64'd0);
      check("mid_rst_keyld", 64'(key_loaded), 64'd0);
      check("mid_rst_err", 64'(err_nokey), 64'd0);
      reset = 1'b1;
      #1;
      check("post_rst_ready", 64'(ready_p), 64'd1);
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_drdy", 64'(data_ready_out_c), 64'd0);
      check("post_rst_level", 64'(fifo_level), 64'd0);
      send("post_rst_nokey", 1'b0, 32'h0000_0022, 5'd0);
      check("post_rst_err", 64'(err_nokey), 64'd1);
      tick();
      check("post_rst_idle_level", 64'(fifo_level), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
